// File: rtl/pkt_maker_tx_if.sv
// NetFPGA-style word stream (data/ctrl/wr/rdy) shared by the pass-through input
// and the merged output of pkt_maker_tx.
//
// Handshake: the receiver drives rdy and the sender drives data/ctrl/wr.
// On an input-side link, a word transfers in any cycle where wr && rdy.
// On an output-side link, wr is registered: a word is launched only in a cycle
// where rdy is high and appears with wr=1 on the following cycle.
interface pkt_maker_tx_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, ctrl, wr, input rdy);
  modport slave  (input data, ctrl, wr, output rdy);
endinterface

// File: rtl/pkt_maker_tx.sv
// Builds generated packets (header words from the generator, then payload words from
// a FWFT FIFO) and merges them between pass-through packets on the output stream.
module pkt_maker_tx #(
  parameter int DATA_WIDTH         = 64,
  parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int HEADER_LENGTH      = 7,
  parameter int HEADER_LENGTH_SIZE = 3,
  parameter int NUM_WORDS_PAYLOAD  = 8,
  parameter int PAYLOAD_CNT_WIDTH  = 8,
  parameter int MIN_GAP            = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  pkt_maker_tx_if.slave                 in_bus,
  pkt_maker_tx_if.master                out_bus,
  output logic [HEADER_LENGTH_SIZE-1:0] header_word_number,
  input  logic [DATA_WIDTH-1:0]         header_data,
  input  logic [CTRL_WIDTH-1:0]         header_ctrl,
  input  logic                          enable,
  output logic                          evt_pkt_sent,
  input  logic [DATA_WIDTH-1:0]         payload_data,
  input  logic                          payload_empty,
  input  logic [PAYLOAD_CNT_WIDTH-1:0]  payload_count,
  output logic                          payload_rd,
  output logic [1:0]                    state_dbg
);

  localparam int CNT_MAX = (HEADER_LENGTH > NUM_WORDS_PAYLOAD) ? HEADER_LENGTH : NUM_WORDS_PAYLOAD;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int GAP_W   = $clog2(MIN_GAP + 1);

  localparam logic [CNT_W-1:0]             HDR_LAST = CNT_W'(HEADER_LENGTH - 1);
  localparam logic [CNT_W-1:0]             PAY_LAST = CNT_W'(NUM_WORDS_PAYLOAD - 1);
  localparam logic [PAYLOAD_CNT_WIDTH-1:0] PAY_NEED = PAYLOAD_CNT_WIDTH'(NUM_WORDS_PAYLOAD);
  localparam logic [GAP_W-1:0]             GAP_INIT = GAP_W'(MIN_GAP);
  localparam logic [CTRL_WIDTH-1:0]        EOP_CTRL = CTRL_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, PASS, HDR, PAY} state_t;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             body_seen;
  logic             gen_ok;

  assign gen_ok = enable && (payload_count >= PAY_NEED) && (gap_cnt == '0);

  // Pass-through is only accepted at packet boundaries when no generated packet is due.
  assign in_bus.rdy = !reset && out_bus.rdy &&
                      (((state == IDLE) && !gen_ok) || (state == PASS));

  assign payload_rd         = !reset && (state == PAY) && out_bus.rdy && !payload_empty;
  assign header_word_number = (state == HDR) ? HEADER_LENGTH_SIZE'(word_cnt) : '0;
  assign state_dbg          = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      out_bus.wr   <= 1'b0;
      out_bus.data <= '0;
      out_bus.ctrl <= '0;
      evt_pkt_sent <= 1'b0;
      word_cnt     <= '0;
      gap_cnt      <= '0;
      body_seen    <= 1'b0;
    end else begin
      out_bus.wr   <= 1'b0;
      evt_pkt_sent <= 1'b0;
      // Nothing advances while downstream has no room.
      if (out_bus.rdy) begin
        case (state)
          IDLE: begin
            if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            if (gen_ok) begin
              state    <= HDR;
              word_cnt <= '0;
            end else if (in_bus.wr) begin
              out_bus.data <= in_bus.data;
              out_bus.ctrl <= in_bus.ctrl;
              out_bus.wr   <= 1'b1;
              body_seen    <= (in_bus.ctrl == '0);
              state        <= PASS;
            end
          end
          PASS: begin
            if (in_bus.wr) begin
              out_bus.data <= in_bus.data;
              out_bus.ctrl <= in_bus.ctrl;
              out_bus.wr   <= 1'b1;
              // A non-zero ctrl after the body marks the end of the packet.
              if (in_bus.ctrl == '0) begin
                body_seen <= 1'b1;
              end else if (body_seen) begin
                body_seen <= 1'b0;
                state     <= IDLE;
              end
            end
          end
          HDR: begin
            out_bus.data <= header_data;
            out_bus.ctrl <= header_ctrl;
            out_bus.wr   <= 1'b1;
            if (word_cnt == HDR_LAST) begin
              state    <= PAY;
              word_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
          PAY: begin
            // An empty FIFO here is an upstream fault; wait rather than emit garbage.
            if (!payload_empty) begin
              out_bus.data <= payload_data;
              out_bus.ctrl <= (word_cnt == PAY_LAST) ? EOP_CTRL : '0;
              out_bus.wr   <= 1'b1;
              if (word_cnt == PAY_LAST) begin
                evt_pkt_sent <= 1'b1;
                gap_cnt      <= GAP_INIT;
                state        <= IDLE;
                word_cnt     <= '0;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
